display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter PRESCALE, default 50000, meaning clock cycles per digit slot; legal range 2..2^20.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_valid  input  1  producer offers load_data this cycle.
REQ-005 load_ready  output  1  block can accept a load this cycle.
REQ-006 load_data  input  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 blank_lz  input  1  when high, leading zeros are blanked; sampled every cycle.
REQ-008 digit  output  4  BCD nibble of the current slot, fed to the seven-segment decoder data input.
REQ-009 digit_en  output  4  one-hot, active-high digit select; bit i drives digit i.
REQ-010 blank  output  1  high when the current slot is blanked.
REQ-011 bcd_err  output  1  one-cycle pulse on an accepted load containing any nibble > 9.

Function
REQ-012 A load SHALL be accepted only when load_valid and load_ready are both high in the same cycle.
REQ-013 An accepted load SHALL write the shadow register and set pending; load_ready SHALL be low from the next cycle while pending is set.
REQ-014 The prescaler SHALL count 0..PRESCALE-1 and wrap; tick SHALL be high in the cycle where count = PRESCALE-1.
REQ-015 On tick, the slot index SHALL advance 0->1->2->3->0.
REQ-016 A tick with index 3 is the frame boundary; if pending, the display register SHALL load the shadow register, clear pending, and raise load_ready the next cycle.
REQ-017 A load accepted in the same cycle as a frame boundary SHALL go to the shadow register and commit at the following boundary. No new load is accepted while a commit is pending, so the old shadow register is never overwritten before it commits.
REQ-018 State machine: EMPTY and RUN.
- EMPTY: entered from reset; all slots blanked.
- EMPTY -> RUN on the first commit.
- RUN has no exit except reset.
REQ-019 The outputs digit, digit_en and blank SHALL be registered and SHALL reflect the new slot index one cycle after tick.
REQ-020 In RUN, slot i SHALL present digit = display nibble i and digit_en = one-hot(i), with blank = 0, except where REQ-021 applies.
REQ-021 A blanked slot SHALL present digit_en = 4'b0000, digit = 4'h0 and blank = 1. A slot is blanked in any of these cases:
- state is EMPTY;
- blank_lz = 1, i > 0, and display nibbles 3 down to i are all zero.
REQ-022 Digit 0 SHALL never be blanked in RUN, so value 0000 displays a single "0".
REQ-023 Nibbles > 9 SHALL be stored and presented unchanged; the decoder defines their segment pattern.
REQ-024 bcd_err SHALL pulse in the cycle after the accepting cycle.
REQ-025 The prescaler SHALL be exactly ceil(log2(PRESCALE)) bits wide. The slot index SHALL be 2 bits and wrap naturally.

Reset
REQ-026 While rst is high on a clock edge, the block SHALL set:
- prescaler = 0, index = 0, state = EMPTY, pending = 0;
- shadow and display registers = 0;
- load_ready = 1, digit = 0, digit_en = 0, blank = 1, bcd_err = 0.
REQ-027 Reset asserted mid-frame or mid-pending SHALL discard the pending load; load_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 rst SHALL take priority over a simultaneous load handshake.

Structure
REQ-029 The shared package SHALL hold:
- the state encoding (EMPTY, RUN);
- the digit count constant NDIG = 4;
- the BCD maximum constant 9.
REQ-030 The prescaler SHALL be a sub-module, scan_tick, with parameter PRESCALE, ports clk, rst and tick.
REQ-031 The decoder SHALL NOT be instantiated inside this block; digit connects externally to the seven-segment decoder.

Verification (bench uses PRESCALE=4)
REQ-032 Reset, then 40 cycles idle -> digit_en = 0 and blank = 1 throughout; load_ready = 1.
REQ-033 Load 16'h1234 with blank_lz = 0 -> after the first frame boundary, digit/digit_en cycle through:
- 4/0001, 3/0010, 2/0100, 1/1000;
- each slot lasts 4 cycles.
REQ-034 Load 16'h0042 with blank_lz = 1 -> slots 3 and 2 are blanked (digit_en = 0, blank = 1); slots 1 and 0 show 4 and 2. Load 16'h0000 -> only slot 0 is lit, showing 0.
REQ-035 Accept 16'h5678, then hold load_valid high with 16'h9999 -> load_ready stays low until the boundary. 5678 displays for one full frame; 9999 commits at the next boundary.
REQ-036 Load 16'h00A1 -> bcd_err high for exactly one cycle after acceptance; slot 1 shows digit = 4'hA.
REQ-037 Assert rst for 1 cycle while pending and mid-frame -> all outputs take their REQ-026 values; the pending data is never displayed.

Source files
------------

// File: rtl/display_scan_pkg.sv
// Shared types and constants for the four-digit multiplexed display scanner.
package display_scan_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } scan_state_t;

    localparam int         NDIG    = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when any of the NDIG nibbles is outside the decimal range.
    function automatic logic has_bad_bcd(input logic [4*NDIG-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (d[4*i +: 4] > BCD_MAX) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/display_scan_tick.sv
// Free-running prescaler: tick is high for one cycle every PRESCALE cycles.
module scan_tick #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/display_scan.sv
// Four-digit BCD display scanner: double-buffered load, per-slot digit select,
// leading-zero blanking and a frame-synchronous commit of new values.
module display_scan
    import display_scan_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [3:0]  digit_en,
    output logic        blank,
    output logic        bcd_err
);

    // Handshake: a load transfers on a rising edge where load_valid and
    // load_ready are both high; load_ready drops while a value waits to commit.

    logic        tick;
    logic [1:0]  idx;
    logic        pending;
    logic [15:0] shadow;
    logic [15:0] disp;
    scan_state_t state, state_n;

    logic        accept;
    logic        commit;
    logic [1:0]  idx_n;
    logic [15:0] disp_n;
    logic        upper_zero;
    logic        lit;
    logic [3:0]  digit_n;
    logic [3:0]  digit_en_n;
    logic        blank_n;

    scan_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign load_ready = !pending;
    assign accept     = load_valid && load_ready;
    assign commit     = tick && (idx == 2'd3) && pending;
    assign idx_n      = tick ? idx + 1'b1 : idx;
    assign disp_n     = commit ? shadow : disp;

    // A commit and an accept can never coincide: commit needs pending,
    // accept needs it clear, so the shadow is never overwritten early.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= 2'd0;
            pending <= 1'b0;
            shadow  <= 16'h0000;
            disp    <= 16'h0000;
            bcd_err <= 1'b0;
        end else begin
            idx  <= idx_n;
            disp <= disp_n;
            if (accept) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            bcd_err <= accept && has_bad_bcd(load_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_EMPTY: if (commit) state_n = ST_RUN;
            ST_RUN:   state_n = ST_RUN;
            default:  state_n = ST_EMPTY;
        endcase
    end

    // Slot outputs are computed from next-cycle index/display so the
    // registered outputs track the new slot right after a tick.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (i >= int'(idx_n) && disp_n[4*i +: 4] != 4'h0) upper_zero = 1'b0;
        end
        lit        = (state_n == ST_RUN) && !(blank_lz && idx_n != 2'd0 && upper_zero);
        digit_n    = 4'h0;
        digit_en_n = 4'b0000;
        blank_n    = 1'b1;
        if (lit) begin
            digit_n    = disp_n[{idx_n, 2'b00} +: 4];
            digit_en_n = 4'b0001 << idx_n;
            blank_n    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit    <= 4'h0;
            digit_en <= 4'b0000;
            blank    <= 1'b1;
        end else begin
            digit    <= digit_n;
            digit_en <= digit_en_n;
            blank    <= blank_n;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: directed vector table, corner-case
// sequences and randomized traffic against a frame-arithmetic reference model.
module tb_display_scan;

    localparam int P     = 4;
    localparam int FRAME = 4 * P;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = 16'h0000;
    logic        blank_lz   = 1'b0;
    logic        load_ready;
    logic [3:0]  digit;
    logic [3:0]  digit_en;
    logic        blank;
    logic        bcd_err;

    int total = 0;
    int bad   = 0;

    display_scan #(.PRESCALE(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_lz   (blank_lz),
        .digit      (digit),
        .digit_en   (digit_en),
        .blank      (blank),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    int          m_cnt;
    logic [15:0] m_disp;
    logic        m_run;
    logic [3:0]  e_digit;
    logic [3:0]  e_en;
    logic        e_blank;
    logic        e_err;
    logic        chk_en = 1'b0;
    int          m_slot;
    logic        m_lit;
    logic        m_acc;

    function automatic logic bad_bcd(input logic [15:0] d);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (((d >> (4 * i)) & 16'h000F) > 16'd9) r = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            exp_q.delete();
            m_disp = 16'h0000;
            m_run  = 1'b0;
            e_err  = 1'b0;
        end else begin
            m_acc = load_valid && (exp_q.size() == 0);
            if ((m_cnt % FRAME) == FRAME - 1 && exp_q.size() != 0) begin
                m_disp = exp_q.pop_front();
                m_run  = 1'b1;
            end
            if (m_acc) exp_q.push_back(load_data);
            e_err = m_acc && bad_bcd(load_data);
            m_cnt++;
        end
        m_slot  = (m_cnt / P) % 4;
        m_lit   = m_run && (m_slot == 0 || !blank_lz || (m_disp >> (4 * m_slot)) != 16'h0000);
        e_digit = m_lit ? 4'((m_disp >> (4 * m_slot)) & 16'h000F) : 4'h0;
        e_en    = m_lit ? 4'(1 << m_slot) : 4'b0000;
        e_blank = !m_lit;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model digit",      16'(digit),      16'(e_digit));
            check("model digit_en",   16'(digit_en),   16'(e_en));
            check("model blank",      16'(blank),      16'(e_blank));
            check("model bcd_err",    16'(bcd_err),    16'(e_err));
            check("model load_ready", 16'(load_ready), 16'(exp_q.size() == 0));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns into the first cycle after reset (prescaler at 0).
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        load_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic        blz;
        logic        err;
        logic [15:0] exp_dig;
        logic [15:0] exp_en;
        logic [3:0]  exp_blank;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 1'b0, 16'h1234, 16'h8421, 4'b0000};
        vecs[1] = '{16'h0042, 1'b1, 1'b0, 16'h0042, 16'h0021, 4'b1100};
        vecs[2] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0001, 4'b1110};
        vecs[3] = '{16'h00A1, 1'b0, 1'b1, 16'h00A1, 16'h8421, 4'b0000};
        vecs[4] = '{16'h0042, 1'b0, 1'b0, 16'h0042, 16'h8421, 4'b0000};
        vecs[5] = '{16'h0300, 1'b1, 1'b0, 16'h0300, 16'h0421, 4'b1000};

        // idle after reset: nothing lit
        do_reset();
        chk_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("idle digit_en", 16'(digit_en), 16'h0);
            check("idle blank", 16'(blank), 16'h1);
            check("idle load_ready", 16'(load_ready), 16'h1);
            cycles(1);
        end

        // table: load at cycle 0, commit at the first boundary, then one frame
        for (int v = 0; v < 6; v++) begin
            do_reset();
            blank_lz   = vecs[v].blz;
            load_valid = 1'b1;
            load_data  = vecs[v].data;
            @(negedge clk);
            check("ready before load", 16'(load_ready), 16'h1);
            cycles(1);
            load_valid = 1'b0;
            @(negedge clk);
            check("bcd_err pulse", 16'(bcd_err), 16'(vecs[v].err));
            cycles(1);
            @(negedge clk);
            check("bcd_err width", 16'(bcd_err), 16'h0);
            check("ready while pending", 16'(load_ready), 16'h0);
            cycles(6);
            @(negedge clk);
            check("empty digit_en", 16'(digit_en), 16'h0);
            check("empty blank", 16'(blank), 16'h1);
            cycles(8);
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < P; c++) begin
                    @(negedge clk);
                    check("vec digit", 16'(digit), 16'(vecs[v].exp_dig[4*s +: 4]));
                    check("vec digit_en", 16'(digit_en), 16'(vecs[v].exp_en[4*s +: 4]));
                    check("vec blank", 16'(blank), 16'(vecs[v].exp_blank[s]));
                    cycles(1);
                end
            end
        end

        // 5678 accepted, 9999 held on the bus until the boundary frees the slot
        blank_lz = 1'b0;
        do_reset();
        load_valid = 1'b1;
        load_data  = 16'h5678;
        cycles(1);
        load_data = 16'h9999;
        @(negedge clk);
        check("held ready low", 16'(load_ready), 16'h0);
        cycles(14);
        @(negedge clk);
        check("ready low at boundary", 16'(load_ready), 16'h0);
        cycles(1);
        @(negedge clk);
        check("ready after commit", 16'(load_ready), 16'h1);
        check("5678 slot0", 16'(digit), 16'h8);
        cycles(1);
        load_valid = 1'b0;
        @(negedge clk);
        check("9999 pending", 16'(load_ready), 16'h0);
        cycles(11);
        @(negedge clk);
        check("5678 slot3", 16'(digit), 16'h5);
        check("5678 slot3 en", 16'(digit_en), 16'h8);
        cycles(3);
        @(negedge clk);
        check("5678 last cycle", 16'(digit), 16'h5);
        cycles(1);
        @(negedge clk);
        check("9999 slot0", 16'(digit), 16'h9);
        check("9999 slot0 en", 16'(digit_en), 16'h1);

        // reset mid-frame while a load is pending: it must never show
        do_reset();
        load_valid = 1'b1;
        load_data  = 16'h1234;
        cycles(1);
        load_valid = 1'b0;
        cycles(7);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst digit", 16'(digit), 16'h0);
        check("rst digit_en", 16'(digit_en), 16'h0);
        check("rst blank", 16'(blank), 16'h1);
        check("rst bcd_err", 16'(bcd_err), 16'h0);
        check("rst load_ready", 16'(load_ready), 16'h1);
        for (int c = 0; c < 40; c++) begin
            cycles(1);
            @(negedge clk);
            check("discarded load dark", 16'(digit_en), 16'h0);
        end

        // randomized traffic, checked cycle by cycle by the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            load_valid = ($urandom_range(0, 1) == 1);
            for (int n = 0; n < 4; n++) begin
                load_data[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            cycles(1);
        end
        rst        = 1'b0;
        load_valid = 1'b0;
        cycles(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
